bus_arbiter: RTL and testbench

//  N-master to single-slave adapter onto the core's simple bus (bus_en/wr_rd/addr/wr_data/size, ack/rd_data).

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_rr_arbiter.sv | 70 +++++++
 rtl/bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus arbiter slice.
//  - bus_state_e : arbiter FSM states (IDLE / BUSY / RESP)
//  - BUS_READ / BUS_WRITE : encoding of the wr_rd bit
//  - ARB_FIXED / ARB_RR   : arbitration mode selector values
//  - gntWidth()  : width of a master index, never narrower than one bit
// ----------------------------------------------------------------------------
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } bus_state_e;

   localparam logic BUS_READ  = 1'b0;
   localparam logic BUS_WRITE = 1'b1;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // A single-master build still needs a one-bit index port.
   function automatic int gntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// ----------------------------------------------------------------------------
// bus_rr_arbiter
// Combinational winner select over N request lines, fixed priority (lowest
// index wins) or round-robin (first set index after the last grant).
// Ports:
//  i_clk, i_rst   clock, asynchronous active-low reset
//  i_req          per-master request lines
//  i_update       grant taken this cycle; pointer follows the winner
//  o_winner       index of the selected master (valid when o_valid)
//  o_valid        at least one request is pending
// ----------------------------------------------------------------------------
module bus_rr_arbiter
   import bus_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int ARB_MODE  = ARB_FIXED
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic [N_MASTERS-1:0]              i_req,
   input  logic                              i_update,
   output logic [gntWidth(N_MASTERS)-1:0]    o_winner,
   output logic                              o_valid
);

   localparam int GW = gntWidth(N_MASTERS);

   logic [GW-1:0] ptr_q;
   logic [GW-1:0] winner_d;
   logic          found;
   int            idx;

   // Pointer starts at the last master so that master 0 is searched first
   // after reset; it only moves when a grant is actually taken.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ptr_q <= GW'(N_MASTERS - 1);
      end else if (i_update && ARB_MODE == ARB_RR) begin
         ptr_q <= winner_d;
      end
   end

   // Round-robin walks ptr+1 .. ptr+N modulo N, so the previous owner is
   // considered last; fixed mode simply takes the lowest set index.
   always_comb begin
      winner_d = '0;
      found    = 1'b0;
      idx      = 0;
      if (ARB_MODE == ARB_RR) begin
         for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(ptr_q) + k) % N_MASTERS;
            if (!found && i_req[idx]) begin
               winner_d = GW'(idx);
               found    = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < N_MASTERS; k++) begin
            if (!found && i_req[k]) begin
               winner_d = GW'(k);
               found    = 1'b1;
            end
         end
      end
   end

   assign o_winner = winner_d;
   assign o_valid  = |i_req;

endmodule

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
// N-master to single-slave adapter onto the simple core bus. Picks a winner
// among the request channels, registers its request onto the bus, waits for
// the slave ack (or a watchdog timeout) and returns a one-cycle completion
// pulse plus read data to the owner.
// Ports:
//  i_clk, i_rst            clock, asynchronous active-low reset
//  i_req/i_wr_rd           per-master request and direction
//  i_addr/i_wr_data/i_size per-master packed request fields
//  o_ready/o_err           one-hot completion / timeout flags
//  o_rd_data               read data, valid with o_ready
//  o_gnt_id                index of the current/last owner
//  i_ack/i_rd_data         slave completion and read data
//  o_bus_en..o_size        registered bus request
// ----------------------------------------------------------------------------
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int N_MASTERS = 2,
   parameter int XLEN      = 32,
   parameter int ARB_MODE  = ARB_FIXED,
   parameter int TIMEOUT   = 0
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [N_MASTERS-1:0]            i_req,
   input  logic [N_MASTERS-1:0]            i_wr_rd,
   input  logic [N_MASTERS*XLEN-1:0]       i_addr,
   input  logic [N_MASTERS*XLEN-1:0]       i_wr_data,
   input  logic [N_MASTERS*3-1:0]          i_size,
   output logic [N_MASTERS-1:0]            o_ready,
   output logic [N_MASTERS-1:0]            o_err,
   output logic [XLEN-1:0]                 o_rd_data,
   output logic [gntWidth(N_MASTERS)-1:0]  o_gnt_id,
   input  logic                            i_ack,
   input  logic [XLEN-1:0]                 i_rd_data,
   output logic                            o_bus_en,
   output logic                            o_wr_rd,
   output logic [XLEN-1:0]                 o_addr,
   output logic [XLEN-1:0]                 o_wr_data,
   output logic [2:0]                      o_size
);

   localparam int GW = gntWidth(N_MASTERS);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   bus_state_e              state_q;
   logic [GW-1:0]           gnt_q;
   logic [GW-1:0]           winner;
   logic                    anyReq;
   logic                    grantTake;
   logic                    expire;
   logic [CW-1:0]           cnt_q;
   logic [CW-1:0]           cnt_d;
   logic [N_MASTERS-1:0]    ownerOneHot;
   logic [N_MASTERS-1:0]    ready_q;
   logic [N_MASTERS-1:0]    err_q;
   logic [XLEN-1:0]         rdData_q;
   logic                    busEn_q;
   logic                    wrRd_q;
   logic [XLEN-1:0]         addr_q;
   logic [XLEN-1:0]         wrData_q;
   logic [2:0]              size_q;

   assign grantTake = (state_q == IDLE) && anyReq;

   bus_rr_arbiter #(
      .N_MASTERS (N_MASTERS),
      .ARB_MODE  (ARB_MODE)
   ) u_arb (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_req    (i_req),
      .i_update (grantTake),
      .o_winner (winner),
      .o_valid  (anyReq)
   );

   // The watchdog only fires when no ack arrives that cycle, so an ack on
   // the expiry cycle completes the transfer normally.
   always_comb begin
      expire = (TIMEOUT != 0) && (state_q == BUSY) && !i_ack && (cnt_q == CNT_LAST);
      cnt_d  = cnt_q;
      if (grantTake) begin
         cnt_d = '0;
      end else if (state_q == BUSY && cnt_q != {CW{1'b1}}) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      ownerOneHot = '0;
      for (int m = 0; m < N_MASTERS; m++) begin
         ownerOneHot[m] = (int'(gnt_q) == m);
      end
   end

   // Single FSM register block: every bus-facing and response output is a
   // flop, so nothing from i_rd_data reaches o_rd_data combinationally.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         cnt_q    <= '0;
         ready_q  <= '0;
         err_q    <= '0;
         rdData_q <= '0;
         busEn_q  <= 1'b0;
         wrRd_q   <= BUS_READ;
         addr_q   <= '0;
         wrData_q <= '0;
         size_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            IDLE: begin
               if (anyReq) begin
                  state_q  <= BUSY;
                  gnt_q    <= winner;
                  busEn_q  <= 1'b1;
                  wrRd_q   <= i_wr_rd[winner];
                  addr_q   <= i_addr[int'(winner)*XLEN +: XLEN];
                  wrData_q <= i_wr_data[int'(winner)*XLEN +: XLEN];
                  size_q   <= i_size[int'(winner)*3 +: 3];
               end
            end
            BUSY: begin
               if (i_ack) begin
                  state_q  <= RESP;
                  busEn_q  <= 1'b0;
                  ready_q  <= ownerOneHot;
                  err_q    <= '0;
                  rdData_q <= (wrRd_q == BUS_WRITE) ? '0 : i_rd_data;
               end else if (expire) begin
                  state_q  <= RESP;
                  busEn_q  <= 1'b0;
                  ready_q  <= ownerOneHot;
                  err_q    <= ownerOneHot;
                  rdData_q <= '0;
               end
            end
            RESP: begin
               state_q <= IDLE;
               ready_q <= '0;
               err_q   <= '0;
            end
            default: begin
               state_q <= IDLE;
               busEn_q <= 1'b0;
               ready_q <= '0;
               err_q   <= '0;
            end
         endcase
      end
   end

   assign o_ready   = ready_q;
   assign o_err     = err_q;
   assign o_rd_data = rdData_q;
   assign o_gnt_id  = gnt_q;
   assign o_bus_en  = busEn_q;
   assign o_wr_rd   = wrRd_q;
   assign o_addr    = addr_q;
   assign o_wr_data = wrData_q;
   assign o_size    = size_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter using three instances:
//  dutA : 2 masters, fixed priority, no watchdog
//  dutB : 3 masters, round-robin, no watchdog
//  dutC : 2 masters, fixed priority, TIMEOUT = 4
// ----------------------------------------------------------------------------
module tb_bus_arbiter;

   logic clk;
   logic rstN;

   // dutA signals
   logic [1:0]  reqA, wrA, readyA, errA;
   logic [63:0] addrA, wdA;
   logic [5:0]  sizeA;
   logic [31:0] rdA, rdInA, addrOutA, wdOutA;
   logic [0:0]  gntA;
   logic        ackA, busEnA, wrOutA;
   logic [2:0]  sizeOutA;

   // dutB signals
   logic [2:0]  reqB, wrB, readyB, errB;
   logic [95:0] addrB, wdB;
   logic [8:0]  sizeB;
   logic [31:0] rdB, rdInB, addrOutB, wdOutB;
   logic [1:0]  gntB;
   logic        ackB, busEnB, wrOutB;
   logic [2:0]  sizeOutB;

   // dutC signals
   logic [1:0]  reqC, wrC, readyC, errC;
   logic [63:0] addrC, wdC;
   logic [5:0]  sizeC;
   logic [31:0] rdC, rdInC, addrOutC, wdOutC;
   logic [0:0]  gntC;
   logic        ackC, busEnC, wrOutC;
   logic [2:0]  sizeOutC;

   int nCompared;
   int nMismatched;

   bus_arbiter #(.N_MASTERS(2), .XLEN(32), .ARB_MODE(0), .TIMEOUT(0)) dutA (
      .i_clk(clk), .i_rst(rstN), .i_req(reqA), .i_wr_rd(wrA), .i_addr(addrA),
      .i_wr_data(wdA), .i_size(sizeA), .o_ready(readyA), .o_err(errA),
      .o_rd_data(rdA), .o_gnt_id(gntA), .i_ack(ackA), .i_rd_data(rdInA),
      .o_bus_en(busEnA), .o_wr_rd(wrOutA), .o_addr(addrOutA),
      .o_wr_data(wdOutA), .o_size(sizeOutA)
   );

   bus_arbiter #(.N_MASTERS(3), .XLEN(32), .ARB_MODE(1), .TIMEOUT(0)) dutB (
      .i_clk(clk), .i_rst(rstN), .i_req(reqB), .i_wr_rd(wrB), .i_addr(addrB),
      .i_wr_data(wdB), .i_size(sizeB), .o_ready(readyB), .o_err(errB),
      .o_rd_data(rdB), .o_gnt_id(gntB), .i_ack(ackB), .i_rd_data(rdInB),
      .o_bus_en(busEnB), .o_wr_rd(wrOutB), .o_addr(addrOutB),
      .o_wr_data(wdOutB), .o_size(sizeOutB)
   );

   bus_arbiter #(.N_MASTERS(2), .XLEN(32), .ARB_MODE(0), .TIMEOUT(4)) dutC (
      .i_clk(clk), .i_rst(rstN), .i_req(reqC), .i_wr_rd(wrC), .i_addr(addrC),
      .i_wr_data(wdC), .i_size(sizeC), .o_ready(readyC), .o_err(errC),
      .o_rd_data(rdC), .o_gnt_id(gntC), .i_ack(ackC), .i_rd_data(rdInC),
      .o_bus_en(busEnC), .o_wr_rd(wrOutC), .o_addr(addrOutC),
      .o_wr_data(wdOutC), .o_size(sizeOutC)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Advance one cycle; outputs are sampled and inputs driven 1 unit after
   // the rising edge, so new inputs take effect on the following edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rstN  = 1'b0;
      reqA  = '0; wrA = '0; addrA = '0; wdA = '0; sizeA = '0; ackA = 1'b0; rdInA = '0;
      reqB  = '0; wrB = '0; addrB = '0; wdB = '0; sizeB = '0; ackB = 1'b0; rdInB = '0;
      reqC  = '0; wrC = '0; addrC = '0; wdC = '0; sizeC = '0; ackC = 1'b0; rdInC = '0;

      applyStimulus();
      applyStimulus();
      checkOutput("rst_bus_en", 32'(busEnA), 32'd0);
      checkOutput("rst_ready", 32'(readyA), 32'd0);
      checkOutput("rst_rd_data", rdA, 32'd0);
      checkOutput("rst_addr", addrOutA, 32'd0);
      rstN = 1'b1;

      // Test 1: m0 read of 0x100, ack on the second BUSY cycle.
      applyStimulus();
      reqA = 2'b01; wrA = 2'b00; addrA[31:0] = 32'h100;
      applyStimulus();
      checkOutput("t1_bus_en_c1", 32'(busEnA), 32'd1);
      checkOutput("t1_addr", addrOutA, 32'h100);
      checkOutput("t1_wr_rd", 32'(wrOutA), 32'd0);
      applyStimulus();
      checkOutput("t1_bus_en_c2", 32'(busEnA), 32'd1);
      checkOutput("t1_ready_c2", 32'(readyA), 32'd0);
      ackA = 1'b1; rdInA = 32'hDEADBEEF;
      applyStimulus();
      checkOutput("t1_ready_c3", 32'(readyA), 32'd1);
      checkOutput("t1_rd_data", rdA, 32'hDEADBEEF);
      checkOutput("t1_bus_en_c3", 32'(busEnA), 32'd0);
      checkOutput("t1_err", 32'(errA), 32'd0);
      ackA = 1'b0; reqA = 2'b00;
      applyStimulus();
      checkOutput("t1_ready_c4", 32'(readyA), 32'd0);

      // Test 4: m1 write of 0x55AA to 0x2004, size 2.
      reqA = 2'b10; wrA = 2'b10; addrA[63:32] = 32'h2004; wdA[63:32] = 32'h55AA;
      sizeA[5:3] = 3'b010;
      applyStimulus();
      checkOutput("t4_bus_en", 32'(busEnA), 32'd1);
      checkOutput("t4_wr_rd", 32'(wrOutA), 32'd1);
      checkOutput("t4_addr", addrOutA, 32'h2004);
      checkOutput("t4_wr_data", wdOutA, 32'h55AA);
      checkOutput("t4_size", 32'(sizeOutA), 32'd2);
      checkOutput("t4_gnt", 32'(gntA), 32'd1);
      ackA = 1'b1; rdInA = 32'h99999999;
      applyStimulus();
      checkOutput("t4_ready", 32'(readyA), 32'b10);
      checkOutput("t4_rd_data", rdA, 32'd0);
      ackA = 1'b0; reqA = 2'b00; wrA = 2'b00;
      applyStimulus();

      // Test 2: fixed priority with both masters requesting.
      reqA = 2'b11;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput($sformatf("t2_gnt_%0d", i), 32'(gntA), 32'd0);
         checkOutput($sformatf("t2_bus_en_%0d", i), 32'(busEnA), 32'd1);
         ackA = 1'b1; rdInA = 32'(i);
         applyStimulus();
         checkOutput($sformatf("t2_ready_%0d", i), 32'(readyA), 32'b01);
         ackA = 1'b0;
         if (i == 2) reqA = 2'b00;
         applyStimulus();
         checkOutput($sformatf("t2_idle_%0d", i), 32'(busEnA), 32'd0);
      end

      // Test 3: round-robin, three masters, ack held high.
      reqB = 3'b111; ackB = 1'b1; rdInB = 32'h0000ABCD;
      begin
         int expGnt [5] = '{0, 1, 2, 0, 1};
         for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("t3_gnt_%0d", i), 32'(gntB), 32'(expGnt[i]));
            applyStimulus();
            checkOutput($sformatf("t3_ready_%0d", i), 32'(readyB), 32'd1 << expGnt[i]);
            if (i == 4) ackB = 1'b0;
            if (i != 4) applyStimulus();
         end
      end

      // Test 6: reset mid-BUSY on dutB; pointer would otherwise pick m2.
      applyStimulus();
      applyStimulus();
      checkOutput("t6_pre_gnt", 32'(gntB), 32'd2);
      checkOutput("t6_pre_bus_en", 32'(busEnB), 32'd1);
      rstN = 1'b0;
      #1;
      checkOutput("t6_bus_en", 32'(busEnB), 32'd0);
      checkOutput("t6_addr", addrOutB, 32'd0);
      checkOutput("t6_gnt", 32'(gntB), 32'd0);
      applyStimulus();
      applyStimulus();
      checkOutput("t6_no_ready", 32'(readyB), 32'd0);
      rstN = 1'b1;
      applyStimulus();
      checkOutput("t6_first_gnt", 32'(gntB), 32'd0);
      checkOutput("t6_bus_en_after", 32'(busEnB), 32'd1);
      ackB = 1'b1;
      applyStimulus();
      checkOutput("t6_ready_after", 32'(readyB), 32'b001);
      ackB = 1'b0; reqB = 3'b000;
      applyStimulus();

      // Test 5: watchdog on dutC. Prime rd_data with a normal read first.
      reqC = 2'b01;
      applyStimulus();
      ackC = 1'b1; rdInC = 32'h12345678;
      applyStimulus();
      checkOutput("t5_prime_rd", rdC, 32'h12345678);
      ackC = 1'b0;
      applyStimulus();
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput($sformatf("t5_busy_%0d", i), 32'(busEnC), 32'd1);
         checkOutput($sformatf("t5_noready_%0d", i), 32'(readyC), 32'd0);
      end
      applyStimulus();
      checkOutput("t5_to_ready", 32'(readyC), 32'b01);
      checkOutput("t5_to_err", 32'(errC), 32'b01);
      checkOutput("t5_to_rd", rdC, 32'd0);
      checkOutput("t5_to_bus_en", 32'(busEnC), 32'd0);
      reqC = 2'b00;
      applyStimulus();
      checkOutput("t5_idle_ready", 32'(readyC), 32'd0);
      checkOutput("t5_idle_err", 32'(errC), 32'd0);

      // Ack on the 4th BUSY cycle beats the watchdog.
      reqC = 2'b01;
      for (int i = 0; i < 4; i++) applyStimulus();
      ackC = 1'b1; rdInC = 32'hCAFEF00D;
      applyStimulus();
      checkOutput("t5_ack_ready", 32'(readyC), 32'b01);
      checkOutput("t5_ack_err", 32'(errC), 32'd0);
      checkOutput("t5_ack_rd", rdC, 32'hCAFEF00D);
      ackC = 1'b0; reqC = 2'b00;
      applyStimulus();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
